// File: rtl/key_event_if.sv
// Event stream from key_event_decoder to the menu/command FSM.
// A valid/ready handshake carrying the key index and the event type.
interface key_event_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_code;
    logic [1:0] ev_type;

    modport master (output ev_valid, output ev_code, output ev_type, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_type, output ev_ready);
endinterface

// File: rtl/key_event_decoder.sv
// Turns debounced press/release ticks into queued SHORT/LONG/REPEAT key events.
// Define KEY_AUTOREPEAT_EN to emit REPEAT events while a key stays held after LONG.
module key_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        neg_tick,
    input  logic        pos_tick,
    input  logic [2:0]  kcode,
    key_event_if.master ev,
    output logic        key_held,
    output logic        overflow
);

    localparam int CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [1:0]       EV_REPEAT = 2'b10;
`endif

    localparam logic [1:0] EV_SHORT = 2'b00;
    localparam logic [1:0] EV_LONG  = 2'b01;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_held_code;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_push;
    logic [1:0]       w_ptype;
    logic             w_rel;

    // Only a release of the key that started the press counts.
    assign w_rel = pos_tick && (kcode == r_held_code);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_ptype     = EV_SHORT;
        case (r_state)
            ST_IDLE: begin
                if (neg_tick) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESSED: begin
                if (w_rel) begin
                    w_push      = 1'b1;
                    w_ptype     = EV_SHORT;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LONG_LAST) begin
                    w_push      = 1'b1;
                    w_ptype     = EV_LONG;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HELD;
                end else begin
                    w_cnt_nxt = sat_inc(r_cnt);
                end
            end
            ST_HELD: begin
                if (w_rel) begin
                    w_state_nxt = ST_IDLE;
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    if (r_cnt == REP_LAST) begin
                        w_push    = 1'b1;
                        w_ptype   = EV_REPEAT;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
`else
                    w_cnt_nxt = r_cnt;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && neg_tick) begin
            r_held_code <= kcode;
        end
    end

    assign key_held = (r_state != ST_IDLE);

    // Event FIFO, first-word-fall-through: head is visible as soon as it is written.
    logic [4:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;

    logic w_full;
    logic w_pop;
    logic w_wr_en;

    assign w_full  = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop   = ev.ev_valid && ev.ev_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr] <= {r_held_code, w_ptype};
        end
    end

    // Head fields are forced to zero while empty so stale entries never show.
    assign ev.ev_valid = (r_count != '0);
    assign ev.ev_code  = ev.ev_valid ? r_mem[r_rd][4:2] : 3'd0;
    assign ev.ev_type  = ev.ev_valid ? r_mem[r_rd][1:0] : 2'd0;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: a time-based event model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_key_event_decoder;
    localparam int LC = 100;
    localparam int RC = 20;
    localparam int FD = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       neg_tick = 1'b0;
    logic       pos_tick = 1'b0;
    logic [2:0] kcode = 3'd0;
    logic       key_held;
    logic       overflow;

    key_event_if evif ();

    key_event_decoder #(
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .neg_tick(neg_tick),
        .pos_tick(pos_tick),
        .kcode   (kcode),
        .ev      (evif),
        .key_held(key_held),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model: events derive from elapsed time since the press, queue holds {code,type}.
    logic [4:0] mq[$];
    bit         m_pressed = 1'b0;
    logic [2:0] m_code = 3'd0;
    int         m_t0 = 0;
    int         cyc = 0;
    bit         m_ovf = 1'b0;
    bit         m_pop;
    bit         m_push;
    logic [4:0] m_ev;
    int         m_d;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            m_pressed = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_pop  = (mq.size() > 0) && evif.ev_ready;
            m_push = 1'b0;
            m_ev   = 5'd0;
            if (!m_pressed) begin
                if (neg_tick) begin
                    m_pressed = 1'b1;
                    m_code = kcode;
                    m_t0 = cyc;
                end
            end else begin
                m_d = cyc - m_t0;
                if (pos_tick && kcode == m_code) begin
                    if (m_d <= LC) begin
                        m_push = 1'b1;
                        m_ev = {m_code, 2'b00};
                    end
                    m_pressed = 1'b0;
                end else if (m_d == LC) begin
                    m_push = 1'b1;
                    m_ev = {m_code, 2'b01};
                end else if (AR && m_d > LC && ((m_d - LC) % RC) == 0) begin
                    m_push = 1'b1;
                    m_ev = {m_code, 2'b10};
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < FD) mq.push_back(m_ev);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", 8'(evif.ev_valid), 8'(mq.size() > 0));
            check("model_code", 8'(evif.ev_code), (mq.size() > 0) ? 8'(mq[0][4:2]) : 8'd0);
            check("model_type", 8'(evif.ev_type), (mq.size() > 0) ? 8'(mq[0][1:0]) : 8'd0);
            check("model_key_held", 8'(key_held), 8'(m_pressed));
            check("model_overflow", 8'(overflow), 8'(m_ovf));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_neg(input logic [2:0] c);
        neg_tick = 1'b1;
        kcode = c;
        @(negedge clk);
        neg_tick = 1'b0;
    endtask

    task automatic pulse_pos(input logic [2:0] c);
        pos_tick = 1'b1;
        kcode = c;
        @(negedge clk);
        pos_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        evif.ev_ready = 1'b1;
        cycles(3);
        reset = 1'b0;
        check("rst_valid", 8'(evif.ev_valid), 8'd0);
        check("rst_code", 8'(evif.ev_code), 8'd0);
        check("rst_type", 8'(evif.ev_type), 8'd0);
        check("rst_key_held", 8'(key_held), 8'd0);
        check("rst_overflow", 8'(overflow), 8'd0);
        chk_en = 1'b1;
        cycles(2);

        // 1: short press, release 10 cycles later
        pulse_neg(3'd1);
        check("t1_held_early", 8'(key_held), 8'd1);
        cycles(9);
        check("t1_held_late", 8'(key_held), 8'd1);
        pulse_pos(3'd1);
        check("t1_valid", 8'(evif.ev_valid), 8'd1);
        check("t1_code", 8'(evif.ev_code), 8'd1);
        check("t1_type", 8'(evif.ev_type), 8'd0);
        check("t1_released", 8'(key_held), 8'd0);
        cycles(1);
        check("t1_single", 8'(evif.ev_valid), 8'd0);
        cycles(3);

        // 2: long hold for 150 cycles
        pulse_neg(3'd3);
        cycles(99);
        check("t2_before_long", 8'(evif.ev_valid), 8'd0);
        cycles(1);
        check("t2_long_valid", 8'(evif.ev_valid), 8'd1);
        check("t2_long_code", 8'(evif.ev_code), 8'd3);
        check("t2_long_type", 8'(evif.ev_type), 8'd1);
        cycles(20);
        check("t2_repeat_valid", 8'(evif.ev_valid), AR ? 8'd1 : 8'd0);
        check("t2_repeat_type", 8'(evif.ev_type), AR ? 8'd2 : 8'd0);
        cycles(29);
        pulse_pos(3'd3);
        check("t2_release_none", 8'(evif.ev_valid), 8'd0);
        check("t2_release_held", 8'(key_held), 8'd0);
        cycles(3);

        // 3: five short presses into a stalled consumer
        evif.ev_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            pulse_neg(3'(c));
            cycles(2);
            pulse_pos(3'(c));
            cycles(1);
        end
        check("t3_overflow", 8'(overflow), 8'd1);
        evif.ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_drain_valid", 8'(evif.ev_valid), 8'd1);
            check("t3_drain_code", 8'(evif.ev_code), 8'(i));
            @(negedge clk);
        end
        check("t3_empty", 8'(evif.ev_valid), 8'd0);
        check("t3_overflow_sticky", 8'(overflow), 8'd1);
        cycles(2);

        // 4: foreign key ticks during a press are ignored
        pulse_neg(3'd2);
        cycles(9);
        pulse_neg(3'd4);
        cycles(4);
        pulse_pos(3'd4);
        check("t4_still_held", 8'(key_held), 8'd1);
        cycles(14);
        pulse_pos(3'd2);
        check("t4_valid", 8'(evif.ev_valid), 8'd1);
        check("t4_code", 8'(evif.ev_code), 8'd2);
        check("t4_type", 8'(evif.ev_type), 8'd0);
        cycles(1);
        check("t4_single", 8'(evif.ev_valid), 8'd0);
        cycles(2);

        // 5: reset in the middle of a press
        pulse_neg(3'd0);
        cycles(49);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_valid", 8'(evif.ev_valid), 8'd0);
        check("t5_key_held", 8'(key_held), 8'd0);
        check("t5_overflow", 8'(overflow), 8'd0);
        cycles(5);
        pulse_pos(3'd0);
        check("t5_orphan_release", 8'(evif.ev_valid), 8'd0);
        cycles(3);

        // 6a: release exactly on the LONG threshold cycle
        pulse_neg(3'd1);
        cycles(99);
        pulse_pos(3'd1);
        check("t6_valid", 8'(evif.ev_valid), 8'd1);
        check("t6_code", 8'(evif.ev_code), 8'd1);
        check("t6_type", 8'(evif.ev_type), 8'd0);
        check("t6_key_held", 8'(key_held), 8'd0);
        cycles(1);
        check("t6_no_long", 8'(evif.ev_valid), 8'd0);
        cycles(5);

        // 6b: full FIFO with push and pop on the same edge
        evif.ev_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            pulse_neg(3'(c));
            cycles(1);
            pulse_pos(3'(c));
            cycles(1);
        end
        pulse_neg(3'd4);
        cycles(2);
        evif.ev_ready = 1'b1;
        pulse_pos(3'd4);
        check("t6_full_no_drop", 8'(overflow), 8'd0);
        for (int i = 1; i < 5; i++) begin
            check("t6_drain_code", 8'(evif.ev_code), 8'(i));
            @(negedge clk);
        end
        check("t6_empty", 8'(evif.ev_valid), 8'd0);
        cycles(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
